// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one W-bit adder between NREQ valid/ready requesters.
// The result sits in a single-entry output register with its own valid/ready handshake.
module adder_share_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id,
  output logic [15:0]       op_count
);

  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_sum_q,   res_sum_d;
  logic            res_carry_q, res_carry_d;
  logic [IDW-1:0]  res_id_q,    res_id_d;
  logic [15:0]     op_count_q,  op_count_d;
  logic [IDW-1:0]  ptr_q,       ptr_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic            slot_free;
  logic            accept;
  logic [W:0]      add_full;

  // Returns {found, index}; scanning offsets downwards lets the offset closest to ptr win.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] pick;
    int           idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) pick = {1'b1, IDW'(idx)};
    end
    return pick;
  endfunction

  assign {gnt_found, gnt_idx} = rr_pick(req_valid, ptr_q);
  assign slot_free = !res_valid_q || res_ready;
  assign accept    = gnt_found && slot_free && !rst;
  assign add_full  = {1'b0, req_a[gnt_idx*W +: W]} + {1'b0, req_b[gnt_idx*W +: W]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_id_d    = res_id_q;
    op_count_d  = op_count_q;
    ptr_d       = ptr_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_sum_d   = add_full[W-1:0];
      res_carry_d = add_full[W];
      res_id_d    = gnt_idx;
      op_count_d  = op_count_q + 16'd1;
      ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= '0;
      op_count_q  <= '0;
      ptr_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_id_q    <= res_id_d;
      op_count_q  <= op_count_d;
      ptr_q       <= ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: expected results are queued at each
// predicted grant and compared when the consumer takes the result.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [W-1:0]   sum;
    logic           carry;
    logic [IDW-1:0] id;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_carry;
  logic [IDW-1:0]    res_id;
  logic [15:0]       op_count;

  res_t        exp_q[$];
  logic [15:0] exp_ops = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  adder_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One clock: check the grant, score any consumed result, queue the result of the expected grant.
  task automatic tick(input logic [NREQ-1:0] exp_ready);
    res_t       e;
    logic [W:0] full;
    int         g;
    @(negedge clk);
    check("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", {31'd0, res_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_sum",   {24'd0, res_sum},   {24'd0, e.sum});
        check("res_carry", {31'd0, res_carry}, {31'd0, e.carry});
        check("res_id",    {30'd0, res_id},    {30'd0, e.id});
      end
    end
    if (exp_ready != '0) begin
      g = 0;
      for (int i = 0; i < NREQ; i++) if (exp_ready[i]) g = i;
      full    = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
      e.sum   = full[W-1:0];
      e.carry = full[W];
      e.id    = IDW'(g);
      exp_q.push_back(e);
      exp_ops = exp_ops + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;

    // Reset held with every requester valid: nothing may be granted.
    @(posedge clk);
    #1;
    tick('0);
    tick('0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_op_count",  {16'd0, op_count},  32'd0);
    rst = 1'b0;

    // Round robin with full throughput; the first grant after reset is requester 0.
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i), 8'h10);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) check("rr_res_valid", {31'd0, res_valid}, 32'd1);
      tick(4'b0001 << (k % 4));
    end
    req_valid = '0;
    check("rr_res_valid_last", {31'd0, res_valid}, 32'd1);
    tick('0);
    check("rr_op_count", {16'd0, op_count}, {16'd0, exp_ops});
    check("rr_drained",  {31'd0, res_valid}, 32'd0);

    // Single addition producing a carry.
    set_op(0, 8'hF0, 8'h25);
    req_valid = 4'b0001;
    tick(4'b0001);
    req_valid = '0;
    check("carry_res_valid", {31'd0, res_valid}, 32'd1);
    check("carry_op_count",  {16'd0, op_count},  32'd9);
    tick('0);

    // Backpressure: result must hold while the consumer stalls.
    res_ready = 1'b0;
    set_op(1, 8'h7F, 8'h01);
    req_valid = 4'b0010;
    tick(4'b0010);
    set_op(2, 8'h33, 8'h44);
    req_valid = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_res_sum",   {24'd0, res_sum},   32'h80);
      check("bp_res_carry", {31'd0, res_carry}, 32'd0);
      check("bp_res_id",    {30'd0, res_id},    32'd1);
      tick('0);
    end
    res_ready = 1'b1;
    tick(4'b0100);
    req_valid = '0;
    tick('0);
    check("bp_op_count", {16'd0, op_count}, 32'd11);

    // Pointer skip: after grant 1, only 3 and 0 valid -> 3 then 0.
    req_valid = 4'b0010;
    tick(4'b0010);
    set_op(3, 8'h05, 8'h06);
    set_op(0, 8'h80, 8'h80);
    req_valid = 4'b1001;
    tick(4'b1000);
    tick(4'b0001);
    req_valid = '0;
    tick('0);
    check("skip_op_count", {16'd0, op_count}, 32'd14);

    // Drive the operation counter to its wrap point.
    set_op(0, 8'h12, 8'h34);
    req_valid = 4'b0001;
    while (exp_ops != 16'hFFFF) tick(4'b0001);
    check("wrap_op_count_max", {16'd0, op_count}, 32'h0000_FFFF);
    tick(4'b0001);
    check("wrap_op_count_zero", {16'd0, op_count}, 32'd0);

    // Reset while a result is pending and stalled: it must be dropped.
    check("midrst_pending", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b0;
    req_valid = '0;
    rst       = 1'b1;
    tick('0);
    exp_q.delete();
    exp_ops = '0;
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_res_sum",   {24'd0, res_sum},   32'd0);
    check("midrst_res_id",    {30'd0, res_id},    32'd0);
    check("midrst_op_count",  {16'd0, op_count},  32'd0);
    rst = 1'b0;

    // First grant after reset goes to the lowest valid index.
    res_ready = 1'b1;
    set_op(2, 8'h01, 8'hFF);
    req_valid = 4'b1100;
    tick(4'b0100);
    req_valid = '0;
    tick('0);
    check("post_rst_op_count", {16'd0, op_count}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
